clock_period_meter: RTL
=======================

# clock_period_meter

Measures the period of an externally generated square wave (typically a divided clock or tone signal) in `inputClock` cycles. It is the receiving end of the team's clock divider: it also reports the half-period count that, loaded into the divider, reproduces the measured signal. It sits on the `inputClock` domain, between asynchronous tone/clock sources and the control logic that tracks or checks their frequency.

## Interface
- `CounterBits`, 16: width of the cycle counter and of `period`.
- `TimeoutCycles`, 50000: cycles without an accepted rising edge before the input is declared dead. Must be ≥ 2 and < 2^CounterBits.

Ports:
- `inputClock` in 1: measurement clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `measuredClock` in 1: asynchronous square wave to be measured.
- `enable` in 1: synchronous enable. Low forces SEEK.
- `period` out CounterBits: last measured rising-edge-to-rising-edge period, in cycles.
- `halfCount` out CounterBits: divider-equivalent count, `(period >> 1) - 1`, saturated at 0.
- `periodValid` out 1: one-cycle pulse when `period` and `halfCount` update.
- `locked` out 1: high while at least one period has been measured and no timeout has occurred since.
- `timedOut` out 1: high from timeout until the next accepted rising edge or until SEEK.

## Operation
- Synchronizer: two flip-flops (`s1`, `s2`) plus history register `s3`. A rising edge is detected in the cycle where `s2 = 1` and `s3 = 0` (`edgeDet`).
- Cycle counter `cnt` (CounterBits):
  - cleared on every `edgeDet`;
  - otherwise increments in MEASURE;
  - holds at 0 in SEEK and TIMEOUT.
- State machine with states SEEK, MEASURE, TIMEOUT. Reset state is SEEK.
  - SEEK:
    - `edgeDet` → MEASURE, `cnt` ← 0.
    - No measurement is produced by this first edge.
  - MEASURE on `edgeDet`:
    - `period` ← `cnt + 1`, `halfCount` ← derived from it.
    - `periodValid` pulses, `locked` ← 1, `cnt` ← 0.
    - State stays MEASURE.
  - MEASURE, no `edgeDet`, `cnt == TimeoutCycles - 1`:
    - → TIMEOUT, `timedOut` ← 1, `locked` ← 0.
    - `period` and `halfCount` keep their last values.
  - TIMEOUT:
    - `edgeDet` → MEASURE, `cnt` ← 0, `timedOut` ← 0.
    - No measurement from this edge.
- `enable = 0` has priority over everything except reset:
  - → SEEK, `cnt` ← 0, `locked` ← 0, `timedOut` ← 0, no `periodValid`.
  - `period` and `halfCount` are held.
- Simultaneous `edgeDet` and `cnt == TimeoutCycles - 1` in MEASURE: the edge wins. `period` = TimeoutCycles, no timeout.
- Width rules:
  - The timeout guarantees `cnt + 1 ≤ TimeoutCycles`, so there is no counter wrap.
  - `halfCount` = 0 when `period < 2`.
  - Odd periods truncate; for example, period 11 gives halfCount 4.
- The synchronizer runs continuously, including while `enable` is low, so an edge present when `enable` rises is handled normally.

## Timing
- Reset values:
  - `period` = 0, `halfCount` = 0, `periodValid` = 0, `locked` = 0, `timedOut` = 0.
  - `cnt` = 0, `s1`/`s2`/`s3` = 0, state SEEK.
- Reset asserted mid-measurement returns everything to reset values immediately (asynchronous). The first edge after release counts as a SEEK edge.
- Latency:
  - A `measuredClock` rise meeting setup before inputClock edge k appears in `s2` after edge k+1.
  - `edgeDet` is true in the cycle after edge k+1.
  - `period`, `halfCount` and `periodValid` are registered and change at edge k+2.
  - Total: 2–3 inputClock cycles from the input rise, depending on phase.
- `periodValid` is exactly one cycle wide and coincident with the new `period`.
- Accepted edges in cycles t0 and t1 give `period` = t1 − t0 exactly. Synchronizer delay cancels out.
- Minimum measurable period is 2 cycles. Input high or low phases shorter than 1 cycle may be missed.
- Timeout: with the last accepted edge at cycle t0 and no later edge, `timedOut` rises at edge t0 + TimeoutCycles + 1.

## Test plan
- Square wave with 5 cycles high and 5 low, `enable` = 1 → the first edge gives no `periodValid`. Each later edge gives `period` = 10, `halfCount` = 4, a one-cycle `periodValid`, and `locked` = 1 after the second edge.
- Odd period of 6 high / 5 low → `period` = 11, `halfCount` = 4 on every measurement. Then switch to 3/3 → the next `period` is 6 or 7 (transition cycle), after which it is steadily 6 with `halfCount` = 2.
- TimeoutCycles = 100, one period of 10, then hold `measuredClock` low → `timedOut` = 1 and `locked` = 0 exactly 100 cycles after the last `cnt` clear, with `period` still 10. The next edge clears `timedOut` and produces no `periodValid`; the following edge gives a measurement.
- TimeoutCycles = 100 with a period of exactly 100 → `periodValid` with `period` = 100, and `timedOut` never asserts.
- Drop `enable` mid-period while locked with period 10 → next cycle `locked` = 0, state SEEK, `period` held at 10. Re-enable → two edges are needed before the next `periodValid`.
- Assert `reset_n` low mid-period → all outputs are 0 immediately. After release, behaviour matches a fresh start.

Source files
------------

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures the measuredClock period in inputClock cycles.
// Ports: inputClock, reset_n, measuredClock, enable -> period, halfCount, periodValid, locked, timedOut.
module clock_period_meter #(
  parameter int CounterBits   = 16,
  parameter int TimeoutCycles = 50000
) (
  input  logic                   inputClock,
  input  logic                   reset_n,
  input  logic                   measuredClock,
  input  logic                   enable,
  output logic [CounterBits-1:0] period,
  output logic [CounterBits-1:0] halfCount,
  output logic                   periodValid,
  output logic                   locked,
  output logic                   timedOut
);

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  localparam logic [CounterBits-1:0] CntLast =
    CounterBits'(TimeoutCycles - 1);

  state_t state_q, state_d;

  logic s1_q, s2_q, s3_q;
  logic edge_det;

  logic [CounterBits-1:0] cnt_q, cnt_d;
  logic [CounterBits-1:0] period_q, period_d;
  logic [CounterBits-1:0] half_q, half_d;
  logic                   pv_q, pv_d;
  logic                   locked_q, locked_d;
  logic                   to_q, to_d;

  logic [CounterBits-1:0] meas_w;
  logic [CounterBits-1:0] half_w;

  // Synchronizer keeps running regardless of enable.
  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= measuredClock;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_det = s2_q & ~s3_q;

  // The current cycle closes the period, hence the +1.
  assign meas_w = cnt_q + 1'b1;
  assign half_w = (meas_w < CounterBits'(2)) ?
                  '0 : (meas_w >> 1) - 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    half_d   = half_q;
    pv_d     = 1'b0;
    locked_d = locked_q;
    to_d     = to_q;

    if (!enable) begin
      state_d  = SEEK;
      cnt_d    = '0;
      locked_d = 1'b0;
      to_d     = 1'b0;
    end else begin
      unique case (state_q)
        SEEK: begin
          cnt_d = '0;
          if (edge_det) state_d = MEASURE;
        end
        MEASURE: begin
          if (edge_det) begin
            period_d = meas_w;
            half_d   = half_w;
            pv_d     = 1'b1;
            locked_d = 1'b1;
            cnt_d    = '0;
          end else if (cnt_q == CntLast) begin
            state_d  = TIMEOUT;
            to_d     = 1'b1;
            locked_d = 1'b0;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        TIMEOUT: begin
          cnt_d = '0;
          if (edge_det) begin
            state_d = MEASURE;
            to_d    = 1'b0;
          end
        end
        default: begin
          state_d = SEEK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge inputClock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SEEK;
      cnt_q    <= '0;
      period_q <= '0;
      half_q   <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      half_q   <= half_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      to_q     <= to_d;
    end
  end

  assign period      = period_q;
  assign halfCount   = half_q;
  assign periodValid = pv_q;
  assign locked      = locked_q;
  assign timedOut    = to_q;

endmodule
